relu_pool: RTL and testbench

Streaming post-processing stage directly downstream of the PE array output. Consumes the PE's signed 8-bit results in raster order, one per beat, and applies optional ReLU. It then performs non-overlapping k×k max-pooling (stride k), k ∈ {1,2,3,4}, and emits pooled values with a valid/ready handshake toward the output buffer. A line buffer of per-output-column partial maxima lets it pool a full feature-map row stream without storing whole rows of pixels.

---
 rtl/relu_pool_pkg.sv | 18 +
 rtl/pool_line_buf.sv | 24 ++
 rtl/relu_pool.sv | 165 ++++++++++++++++
 tb/tb_relu_pool.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/relu_pool_pkg.sv
// Shared encodings for relu_pool and the sequencer that drives the PE array and this stage.
package relu_pool_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_e;

    // Encoded as pool size minus one, matching the i_pool input.
    typedef enum logic [1:0] {
        POOL_1X1 = 2'd0,
        POOL_2X2 = 2'd1,
        POOL_3X3 = 2'd2,
        POOL_4X4 = 2'd3
    } pool_e;

endpackage

// File: rtl/pool_line_buf.sv
// Per-output-column partial maxima: combinational read and synchronous write at one index.
module pool_line_buf #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                         i_clk,
    input  logic                         i_we,
    input  logic [AW-1:0]                i_addr,
    input  logic signed [DATA_WIDTH-1:0] i_wdata,
    output logic signed [DATA_WIDTH-1:0] o_rdata
);

    logic signed [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = mem_q[i_addr];

endmodule

// File: rtl/relu_pool.sv
// Streaming ReLU plus non-overlapping k x k max-pooling of a raster-order sample stream.
module relu_pool
    import relu_pool_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int MAX_WIDTH  = 64,
    parameter int DIM_BITS   = 7
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_start,
    input  logic                         i_relu,
    input  logic [1:0]                   i_pool,
    input  logic [DIM_BITS-1:0]          i_fmap_width,
    input  logic [DIM_BITS-1:0]          i_fmap_height,
    input  logic                         i_valid,
    input  logic signed [DATA_WIDTH-1:0] i_data,
    output logic                         o_ready,
    output logic                         o_valid,
    output logic signed [DATA_WIDTH-1:0] o_data,
    output logic                         o_last,
    input  logic                         i_ready,
    output logic                         o_busy,
    output logic                         o_done
);

    localparam int AW = $clog2(MAX_WIDTH / 2);

    typedef logic signed [DATA_WIDTH-1:0] sample_t;

    function automatic sample_t smax(input sample_t a, input sample_t b);
        return (a > b) ? a : b;
    endfunction

    state_e              state_q;
    logic                relu_q;
    pool_e               kmax_q;
    logic [DIM_BITS-1:0] w_q, h_q;
    logic [DIM_BITS-1:0] col_q, row_q;
    logic [1:0]          cx_q, ry_q;
    logic [AW-1:0]       oc_q;
    sample_t             hmax_q;
    logic                o_valid_q, o_last_q, done_q;
    sample_t             o_data_q;

    sample_t             x, h_d, buf_rd, buf_wd, emit_data;
    logic                acc, hs, seg_done, emit, buf_we, last_col, last_px, last_win;
    logic [DIM_BITS:0]   col_end, row_end;

    always_comb begin
        x         = (relu_q && i_data < 0) ? '0 : i_data;
        h_d       = (cx_q == 2'd0) ? x : smax(hmax_q, x);
        acc       = o_ready && i_valid;
        hs        = o_valid_q && i_ready;
        seg_done  = (cx_q == kmax_q);
        emit      = acc && seg_done && (ry_q == kmax_q);
        emit_data = (kmax_q == POOL_1X1) ? h_d : smax(buf_rd, h_d);
        buf_we    = acc && seg_done && (ry_q != kmax_q);
        buf_wd    = (ry_q == 2'd0) ? h_d : smax(buf_rd, h_d);
        last_col  = (col_q == w_q - 1'b1);
        last_px   = last_col && (row_q == h_q - 1'b1);
        // Last window iff no further full segment fits to the right or below.
        col_end   = {1'b0, col_q} + (DIM_BITS+1)'(kmax_q) + 1'b1;
        row_end   = {1'b0, row_q} + (DIM_BITS+1)'(kmax_q) + 1'b1;
        last_win  = (col_end >= {1'b0, w_q}) && (row_end >= {1'b0, h_q});
    end

    assign o_ready = (state_q == RUN) && (!o_valid_q || i_ready);
    assign o_valid = o_valid_q;
    assign o_data  = o_data_q;
    assign o_last  = o_last_q;
    assign o_busy  = (state_q != IDLE);
    assign o_done  = done_q;

    pool_line_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MAX_WIDTH / 2),
        .AW         (AW)
    ) u_line_buf (
        .i_clk   (i_clk),
        .i_we    (buf_we),
        .i_addr  (oc_q),
        .i_wdata (buf_wd),
        .o_rdata (buf_rd)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= IDLE;
            relu_q    <= 1'b0;
            kmax_q    <= POOL_1X1;
            w_q       <= '0;
            h_q       <= '0;
            col_q     <= '0;
            row_q     <= '0;
            cx_q      <= '0;
            ry_q      <= '0;
            oc_q      <= '0;
            hmax_q    <= '0;
            o_valid_q <= 1'b0;
            o_last_q  <= 1'b0;
            o_data_q  <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (hs) begin
                o_valid_q <= 1'b0;
                o_last_q  <= 1'b0;
            end
            if (emit) begin
                o_valid_q <= 1'b1;
                o_data_q  <= emit_data;
                o_last_q  <= last_win;
            end
            case (state_q)
                IDLE: begin
                    // A start landing on the done cycle is dropped.
                    if (i_start && !done_q) begin
                        relu_q  <= i_relu;
                        kmax_q  <= pool_e'(i_pool);
                        w_q     <= i_fmap_width;
                        h_q     <= i_fmap_height;
                        col_q   <= '0;
                        row_q   <= '0;
                        cx_q    <= '0;
                        ry_q    <= '0;
                        oc_q    <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    if (acc) begin
                        hmax_q <= h_d;
                        if (last_col) begin
                            col_q <= '0;
                            cx_q  <= '0;
                            oc_q  <= '0;
                            row_q <= row_q + 1'b1;
                            ry_q  <= (ry_q == kmax_q) ? 2'd0 : ry_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                            if (seg_done) begin
                                cx_q <= '0;
                                oc_q <= oc_q + 1'b1;
                            end else begin
                                cx_q <= cx_q + 1'b1;
                            end
                        end
                        if (last_px) begin
                            state_q <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (!o_valid_q || i_ready) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_relu_pool.sv
// Directed bench for relu_pool: vector table of whole frames plus stall, reset and start-filter sequences.
module tb_relu_pool;

    logic              clk = 1'b0;
    logic              i_rst, i_start, i_relu, i_valid, i_ready;
    logic [1:0]        i_pool;
    logic [6:0]        i_fmap_width, i_fmap_height;
    logic signed [7:0] i_data;
    logic              o_ready, o_valid, o_last, o_busy, o_done;
    logic signed [7:0] o_data;

    int n_cmp = 0;
    int n_fail = 0;
    int in_q[$];
    int exp_q[$];

    always #5 clk = ~clk;

    relu_pool #(.DATA_WIDTH(8), .MAX_WIDTH(64), .DIM_BITS(7)) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_relu        (i_relu),
        .i_pool        (i_pool),
        .i_fmap_width  (i_fmap_width),
        .i_fmap_height (i_fmap_height),
        .i_valid       (i_valid),
        .i_data        (i_data),
        .o_ready       (o_ready),
        .o_valid       (o_valid),
        .o_data        (o_data),
        .o_last        (o_last),
        .i_ready       (i_ready),
        .o_busy        (o_busy),
        .o_done        (o_done)
    );

    typedef struct {
        bit relu;
        int pool;
        int w;
        int h;
        int base;
        int step;
        int nexp;
        int e0, e1, e2, e3;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic load_ramp(input int base, input int step, input int n);
        in_q.delete();
        for (int i = 0; i < n; i++) in_q.push_back(base + step * i);
    endtask

    task automatic run_frame(input bit relu, input int pool, input int w, input int h,
                             input int stall, input bit mid_start, input bit start_at_done,
                             input string nm);
        int idx = 0;
        int oidx = 0;
        int done_cnt = 0;
        int stall_left = stall;
        int tail = -1;
        bit acc, hs;
        @(negedge clk);
        i_start = 1'b1; i_relu = relu; i_pool = 2'(pool);
        i_fmap_width = 7'(w); i_fmap_height = 7'(h);
        i_valid = 1'b0; i_ready = 1'b1;
        @(negedge clk);
        i_relu = !relu; i_pool = ~(2'(pool)); i_fmap_width = '0; i_fmap_height = '0;
        for (int cyc = 0; cyc < 2000 && tail != 0; cyc++) begin
            i_start = mid_start && (idx == 3);
            if (mid_start) begin
                i_pool = 2'd0; i_fmap_width = 7'd1; i_fmap_height = 7'd1;
            end
            i_valid = (idx < in_q.size());
            if (i_valid) i_data = 8'(in_q[idx]);
            else         i_data = '0;
            i_ready = !(o_valid && stall_left > 0);
            #1;
            if (o_valid && !i_ready) begin
                chk({nm, " stall_o_ready"}, int'(o_ready), 0);
                if (oidx < exp_q.size()) chk({nm, " stall_o_data"}, int'(o_data), exp_q[oidx]);
                stall_left--;
            end
            acc = i_valid && o_ready;
            hs  = o_valid && i_ready;
            if (hs) begin
                if (oidx < exp_q.size()) begin
                    chk($sformatf("%s out%0d_data", nm, oidx), int'(o_data), exp_q[oidx]);
                    chk($sformatf("%s out%0d_last", nm, oidx), int'(o_last),
                        (oidx == exp_q.size() - 1) ? 1 : 0);
                end else begin
                    chk({nm, " extra_output"}, oidx + 1, exp_q.size());
                end
                oidx++;
            end
            if (o_done) begin
                done_cnt++;
                if (tail < 0) tail = 3;
                if (start_at_done) begin
                    i_start = 1'b1; i_pool = 2'd0;
                    i_fmap_width = 7'd2; i_fmap_height = 7'd1;
                end
            end
            @(posedge clk);
            if (acc) idx++;
            if (tail > 0) tail--;
            @(negedge clk);
        end
        i_start = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        #1;
        chk({nm, " accepted"}, idx, in_q.size());
        chk({nm, " out_count"}, oidx, exp_q.size());
        chk({nm, " done_pulses"}, done_cnt, 1);
        chk({nm, " busy_after"}, int'(o_busy), 0);
    endtask

    initial begin
        int n;
        bit acc;
        i_rst = 1'b1; i_start = 1'b0; i_relu = 1'b0; i_pool = '0;
        i_fmap_width = '0; i_fmap_height = '0; i_valid = 1'b0; i_data = '0; i_ready = 1'b1;
        #12;
        chk("reset o_valid", int'(o_valid), 0);
        chk("reset o_busy", int'(o_busy), 0);
        chk("reset o_done", int'(o_done), 0);
        chk("reset o_ready", int'(o_ready), 0);
        chk("reset o_data", int'(o_data), 0);
        @(negedge clk);
        i_rst = 1'b0;

        tbl[0] = '{1, 0, 2, 1, -5, 8, 2, 0, 3, 0, 0};
        tbl[1] = '{0, 1, 4, 4, 0, 1, 4, 5, 7, 13, 15};
        tbl[2] = '{1, 1, 4, 4, -8, 1, 4, 0, 0, 5, 7};
        tbl[3] = '{0, 1, 4, 4, -8, 1, 4, -3, -1, 5, 7};
        tbl[4] = '{0, 0, 3, 1, 100, 10, 3, 100, 110, 120, 0};
        tbl[5] = '{0, 1, 5, 3, 0, 1, 2, 6, 8, 0, 0};
        tbl[6] = '{0, 3, 4, 4, -20, 1, 1, -5, 0, 0, 0};

        for (int t = 0; t < 7; t++) begin
            load_ramp(tbl[t].base, tbl[t].step, tbl[t].w * tbl[t].h);
            exp_q = '{tbl[t].e0, tbl[t].e1, tbl[t].e2, tbl[t].e3};
            while (exp_q.size() > tbl[t].nexp) void'(exp_q.pop_back());
            run_frame(tbl[t].relu, tbl[t].pool, tbl[t].w, tbl[t].h, 0, 1'b0, 1'b0,
                      $sformatf("vec%0d", t));
        end

        // k=3, W=7, H=4: unique max -2 at (1,4); column 6 and row 3 hold larger values to be dropped
        in_q.delete();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 7; c++)
                in_q.push_back((r == 3 || c == 6) ? -1 : ((r == 1 && c == 4) ? -2 : -50));
        exp_q = '{-50, -2};
        run_frame(1'b0, 2, 7, 4, 0, 1'b0, 1'b0, "k3_leftover");

        load_ramp(0, 1, 16);
        exp_q = '{5, 7, 13, 15};
        run_frame(1'b0, 1, 4, 4, 5, 1'b0, 1'b0, "stall");

        load_ramp(-5, 8, 2);
        exp_q = '{0, 3};
        run_frame(1'b1, 0, 2, 1, 0, 1'b0, 1'b1, "start_on_done");

        load_ramp(1, 1, 9);
        exp_q.delete();
        run_frame(1'b0, 3, 3, 3, 0, 1'b1, 1'b0, "k4_small");

        // Abandon a frame after 7 accepted inputs, then verify a clean rerun.
        @(negedge clk);
        i_start = 1'b1; i_relu = 1'b0; i_pool = 2'd1; i_fmap_width = 7'd4; i_fmap_height = 7'd4;
        @(negedge clk);
        i_start = 1'b0;
        n = 0;
        for (int cyc = 0; cyc < 100 && n < 7; cyc++) begin
            i_valid = 1'b1; i_data = 8'sd100; i_ready = 1'b1;
            #1;
            acc = o_ready;
            @(posedge clk);
            if (acc) n++;
            @(negedge clk);
        end
        i_valid = 1'b0;
        chk("midrst fed", n, 7);
        #2 i_rst = 1'b1;
        #1;
        chk("midrst o_valid", int'(o_valid), 0);
        chk("midrst o_busy", int'(o_busy), 0);
        chk("midrst o_data", int'(o_data), 0);
        chk("midrst o_last", int'(o_last), 0);
        @(negedge clk);
        i_rst = 1'b0;
        load_ramp(0, 1, 16);
        exp_q = '{5, 7, 13, 15};
        run_frame(1'b0, 1, 4, 4, 0, 1'b0, 1'b0, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
